match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter N_PLAYERS, default 2, number of players/paddles, legal range 2..4.
REQ-002 Parameter SCORE_W, default 4, bit width of each player score.
REQ-003 Parameter WIN_SCORE, default 3, points needed to win; legal range 1..2^SCORE_W-1.
REQ-004 Parameter SERVE_DELAY, default 50_000_000, clk cycles from entering SERVE_WAIT to the serve pulse; legal minimum 1.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse (debounced Enter key) that begins or restarts a match.
REQ-008 pause  in  1  one-cycle pulse that toggles pause.
REQ-009 mode_load  in  1  one-cycle pulse that latches mode_sel.
REQ-010 mode_sel  in  2  requested mode: 0 versus, 1 practice, 2 sudden death, 3 treated as 0.
REQ-011 point_valid  in  1  one-cycle pulse from the ball logic: a point was won.
REQ-012 point_id  in  PID_W=max(1,$clog2(N_PLAYERS))  index of the player credited with the point.
REQ-013 state  out  3  IDLE=0, SERVE_WAIT=1, PLAY=2, PAUSED=3, OVER=4.
REQ-014 scores  out  N_PLAYERS*SCORE_W  packed scores; player k occupies bits [k*SCORE_W +: SCORE_W].
REQ-015 mode  out  2  active latched mode.
REQ-016 serve  out  1  one-cycle pulse that launches the ball.
REQ-017 serve_to  out  PID_W  player toward whom the ball is served.
REQ-018 winner  out  PID_W  winning player index; valid only while state==OVER.

Function
REQ-019 IDLE: start -> SERVE_WAIT with scores cleared, serve_to=0 and the delay counter cleared; other inputs have no effect except mode_load.
REQ-020 SERVE_WAIT: counter increments each cycle; on the cycle the count reaches SERVE_DELAY-1, serve=1 for exactly that cycle, the counter clears and the next state is PLAY.
REQ-021 PLAY: an accepted point_valid increments scores[point_id] by 1, sets serve_to=point_id and moves to SERVE_WAIT; if the new score equals the effective win score, the state moves to OVER with winner=point_id instead.
REQ-022 The effective win score is WIN_SCORE in mode 0/3 and 1 in mode 2; in mode 1 points update serve_to and return to SERVE_WAIT without changing scores, and OVER is never entered.
REQ-023 point_valid is ignored when point_id>=N_PLAYERS and in every state other than PLAY.
REQ-024 Scores saturate: no score ever exceeds the effective win score or wraps past 2^SCORE_W-1.
REQ-025 pause in PLAY or SERVE_WAIT -> PAUSED, with the origin state saved and the delay counter frozen; pause in PAUSED returns to the saved state, resuming the count from the frozen value.
REQ-026 If point_valid and pause arrive in the same PLAY cycle, the point is taken and the pause is dropped.
REQ-027 start in SERVE_WAIT, PLAY or PAUSED restarts the match (same action as REQ-019) and has priority over pause and point_valid.
REQ-028 OVER: outputs hold; start -> SERVE_WAIT as in REQ-019; pause and point_valid are ignored.
REQ-029 mode_load is accepted only in IDLE or OVER (mode<=mode_sel, 3 stored as 0) and is ignored in all other states.
REQ-030 All outputs are registered; serve is never asserted outside the SERVE_WAIT->PLAY transition cycle.

Reset
REQ-031 rst=1 at a clock edge forces state=IDLE, scores=0, mode=0, serve=0, serve_to=0, winner=0, counter=0 and saved state=IDLE, overriding all other inputs in any state, mid-match included.

Verification
REQ-032 Parameters: N=2, WIN=3, SERVE_DELAY=4. start in IDLE -> state=1 for 4 cycles, serve high for 1 cycle with serve_to=0, then state=2.
REQ-033 Three point_valid pulses with id=1 (each after its serve) -> scores=0x30 after the third, state=4, winner=1; a further point_valid leaves scores=0x30.
REQ-034 pause after 2 SERVE_WAIT cycles, hold 10 cycles, pause again -> no serve while paused; serve occurs exactly 2 cycles after resume.
REQ-035 point_valid+pause in the same PLAY cycle, id=0 -> score0=1, state=1 (not 3); point_id=1 with N=2 but point_valid outside PLAY -> no change.
REQ-036 mode_load with mode_sel=2 in IDLE, then start and one point id=0 -> state=4, winner=0; mode_load during PLAY -> mode unchanged; mode_sel=1 -> 5 points, scores stay 0.
REQ-037 rst asserted in PAUSED with scores 0x12 -> next cycle state=0, scores=0, serve=0; start in OVER -> scores=0, state=1.

Source files
------------

// File: rtl/match_ctrl.sv
// Match controller: sequences serve/play/pause/game-over and keeps per-player scores.
// Latency: every output is registered, so a response appears one clk after its input pulse.
// Backpressure: none; inputs are one-cycle pulses, and any pulse not legal in the current state is dropped.
module match_ctrl #(
  parameter int N_PLAYERS   = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 3,
  parameter int SERVE_DELAY = 50_000_000,
  localparam int PID_W      = ($clog2(N_PLAYERS) > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         mode_load,
  input  logic [1:0]                   mode_sel,
  input  logic                         point_valid,
  input  logic [PID_W-1:0]             point_id,
  output logic [2:0]                   state,
  output logic [N_PLAYERS*SCORE_W-1:0] scores,
  output logic [1:0]                   mode,
  output logic                         serve,
  output logic [PID_W-1:0]             serve_to,
  output logic [PID_W-1:0]             winner
);

  localparam int CNT_W = ($clog2(SERVE_DELAY) > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PID_W:0]     N_LIMIT  = (PID_W + 1)'(N_PLAYERS);
  localparam logic [SCORE_W-1:0] WIN_Q    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_S    = SCORE_W'(1);

  localparam logic [1:0] MODE_VERSUS   = 2'd0;
  localparam logic [1:0] MODE_PRACTICE = 2'd1;
  localparam logic [1:0] MODE_SUDDEN   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_PLAY       = 3'd2,
    S_PAUSED     = 3'd3,
    S_OVER       = 3'd4
  } state_e;

  state_e                         state_q;
  state_e                         saved_q;
  logic [N_PLAYERS*SCORE_W-1:0]   scores_q;
  logic [N_PLAYERS*SCORE_W-1:0]   scores_d;
  logic [1:0]                     mode_q;
  logic                           serve_q;
  logic [PID_W-1:0]               serve_to_q;
  logic [PID_W-1:0]               winner_q;
  logic [CNT_W-1:0]               cnt_q;

  logic [SCORE_W-1:0]             cur_score;
  logic [SCORE_W-1:0]             new_score;
  logic [SCORE_W-1:0]             eff_win;
  logic                           pt_ok;
  logic                           hit_win;

  // Candidate score vector for a point credited to point_id, saturating at the win score.
  always_comb begin
    cur_score = '0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (point_id == PID_W'(k)) cur_score = scores_q[k*SCORE_W +: SCORE_W];
    end
    eff_win   = (mode_q == MODE_SUDDEN) ? ONE_S : WIN_Q;
    new_score = (cur_score < eff_win) ? cur_score + ONE_S : cur_score;
    hit_win   = (new_score == eff_win);
    pt_ok     = point_valid && ({1'b0, point_id} < N_LIMIT);
    scores_d  = scores_q;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (point_id == PID_W'(k)) scores_d[k*SCORE_W +: SCORE_W] = new_score;
    end
  end

  // Match FSM; start restarts from any state and outranks pause and point_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      saved_q    <= S_IDLE;
      scores_q   <= '0;
      mode_q     <= MODE_VERSUS;
      serve_q    <= 1'b0;
      serve_to_q <= '0;
      winner_q   <= '0;
      cnt_q      <= '0;
    end else begin
      serve_q <= 1'b0;

      // Mode can only change between matches, never while one is running.
      if (mode_load && (state_q == S_IDLE || state_q == S_OVER)) begin
        mode_q <= (mode_sel == 2'd3) ? MODE_VERSUS : mode_sel;
      end

      if (start) begin
        state_q    <= S_SERVE_WAIT;
        scores_q   <= '0;
        serve_to_q <= '0;
        winner_q   <= '0;
        cnt_q      <= '0;
      end else begin
        case (state_q)
          S_SERVE_WAIT: begin
            if (pause) begin
              saved_q <= S_SERVE_WAIT;
              state_q <= S_PAUSED;
            end else if (cnt_q == CNT_LAST) begin
              serve_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_PLAY;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          S_PLAY: begin
            // A point in the same cycle as pause wins; the pause is dropped.
            if (pt_ok) begin
              serve_to_q <= point_id;
              cnt_q      <= '0;
              if (mode_q == MODE_PRACTICE) begin
                state_q <= S_SERVE_WAIT;
              end else begin
                scores_q <= scores_d;
                if (hit_win) begin
                  winner_q <= point_id;
                  state_q  <= S_OVER;
                end else begin
                  state_q <= S_SERVE_WAIT;
                end
              end
            end else if (pause) begin
              saved_q <= S_PLAY;
              state_q <= S_PAUSED;
            end
          end
          S_PAUSED: begin
            // Counter is left untouched so serve-wait resumes where it stopped.
            if (pause) state_q <= saved_q;
          end
          S_IDLE, S_OVER: begin
            state_q <= state_q;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign state    = state_q;
  assign scores   = scores_q;
  assign mode     = mode_q;
  assign serve    = serve_q;
  assign serve_to = serve_to_q;
  assign winner   = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl with N=2, WIN=3, SERVE_DELAY=4.
// Expected serve targets are queued as stimulus is driven and popped by a serve monitor.
module tb_match_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       mode_load = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       point_valid = 1'b0;
  logic [0:0] point_id = 1'b0;
  logic [2:0] state;
  logic [7:0] scores;
  logic [1:0] mode;
  logic       serve;
  logic [0:0] serve_to;
  logic [0:0] winner;

  int n_chk = 0;
  int n_fail = 0;
  logic [0:0] sb_q[$];

  match_ctrl #(
    .N_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(3), .SERVE_DELAY(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .mode_load(mode_load), .mode_sel(mode_sel),
    .point_valid(point_valid), .point_id(point_id),
    .state(state), .scores(scores), .mode(mode), .serve(serve),
    .serve_to(serve_to), .winner(winner)
  );

  always #5 clk = ~clk;

  // Serve monitor: every serve must match the oldest queued expectation and occur in PLAY.
  always @(negedge clk) begin
    if (serve === 1'b1) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_serve: serve=1 serve_to=%0d, no serve expected", serve_to);
      end else begin
        logic [0:0] exp_to;
        exp_to = sb_q.pop_front();
        if (serve_to !== exp_to || state !== 3'd2) begin
          n_fail++;
          $display("FAIL serve_sb: serve_to=%0d state=%0d, expected serve_to=%0d state=2",
                   serve_to, state, exp_to);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    sb_q.push_back(1'b0);
  endtask

  task automatic do_point(input logic [0:0] id);
    point_valid = 1'b1;
    point_id    = id;
    tick();
    point_valid = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    tick();
    pause = 1'b0;
  endtask

  task automatic load_mode(input logic [1:0] m);
    mode_sel  = m;
    mode_load = 1'b1;
    tick();
    mode_load = 1'b0;
  endtask

  // Cycles until serve is observed, bounded at 50.
  task automatic go_serve(output int c);
    c = 0;
    while (serve !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    start = 1'b1; pause = 1'b1; point_valid = 1'b1; mode_load = 1'b1; mode_sel = 2'd2;
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; pause = 1'b0; point_valid = 1'b0; mode_load = 1'b0;
    n_chk++;
    if (state !== 3'd0 || scores !== 8'h00 || mode !== 2'd0 || serve !== 1'b0 ||
        serve_to !== 1'b0 || winner !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d scores=%h mode=%0d serve=%b serve_to=%0d winner=%0d, expected all 0",
               state, scores, mode, serve, serve_to, winner);
    end
  endtask

  task automatic test_serve_timing();
    int sw;
    do_reset();
    do_start();
    sw = 0;
    while (state === 3'd1 && sw < 20) begin
      sw++;
      tick();
    end
    n_chk++;
    if (sw != 4) begin
      n_fail++; $display("FAIL serve_wait_len: %0d cycles in SERVE_WAIT, expected 4", sw);
    end
    n_chk++;
    if (serve !== 1'b1 || state !== 3'd2 || serve_to !== 1'b0) begin
      n_fail++;
      $display("FAIL serve_pulse: serve=%b state=%0d serve_to=%0d, expected 1/2/0", serve, state, serve_to);
    end
    tick();
    n_chk++;
    if (serve !== 1'b0 || state !== 3'd2) begin
      n_fail++; $display("FAIL serve_one_cycle: serve=%b state=%0d, expected 0/2", serve, state);
    end
  endtask

  task automatic test_points();
    int c;
    logic [7:0] exp_sc;
    do_reset();
    do_start();
    exp_sc = 8'h00;
    for (int i = 0; i < 3; i++) begin
      go_serve(c);
      n_chk++;
      if (c != 4) begin
        n_fail++; $display("FAIL point_serve_delay%0d: %0d cycles, expected 4", i, c);
      end
      do_point(1'b1);
      exp_sc = exp_sc + 8'h10;
      if (i < 2) sb_q.push_back(1'b1);
      n_chk++;
      if (scores !== exp_sc || state !== ((i < 2) ? 3'd1 : 3'd4) || serve_to !== 1'b1) begin
        n_fail++;
        $display("FAIL point%0d: scores=%h state=%0d serve_to=%0d, expected %h/%0d/1",
                 i, scores, state, serve_to, exp_sc, (i < 2) ? 1 : 4);
      end
    end
    n_chk++;
    if (winner !== 1'b1) begin
      n_fail++; $display("FAIL winner_p1: winner=%0d, expected 1", winner);
    end
    do_point(1'b1);
    do_pause();
    tick();
    n_chk++;
    if (scores !== 8'h30 || state !== 3'd4 || winner !== 1'b1) begin
      n_fail++;
      $display("FAIL over_hold: scores=%h state=%0d winner=%0d, expected 30/4/1", scores, state, winner);
    end
  endtask

  task automatic test_pause();
    int c;
    int bad;
    do_reset();
    do_start();
    tick();
    tick();
    do_pause();
    n_chk++;
    if (state !== 3'd3) begin
      n_fail++; $display("FAIL pause_enter: state=%0d, expected 3", state);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (serve !== 1'b0 || state !== 3'd3) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL pause_hold: %0d bad cycles, expected 0", bad);
    end
    do_pause();
    n_chk++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL pause_resume: state=%0d, expected 1", state);
    end
    go_serve(c);
    n_chk++;
    if (c != 2) begin
      n_fail++; $display("FAIL resume_serve_delay: %0d cycles, expected 2", c);
    end
    tick();
    do_pause();
    n_chk++;
    if (state !== 3'd3) begin
      n_fail++; $display("FAIL pause_play: state=%0d, expected 3", state);
    end
    do_pause();
    n_chk++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL resume_play: state=%0d, expected 2", state);
    end
  endtask

  task automatic test_point_pause();
    int c;
    do_reset();
    do_start();
    go_serve(c);
    point_valid = 1'b1; point_id = 1'b0; pause = 1'b1;
    tick();
    point_valid = 1'b0; pause = 1'b0;
    sb_q.push_back(1'b0);
    n_chk++;
    if (scores !== 8'h01 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL point_and_pause: scores=%h state=%0d, expected 01/1", scores, state);
    end
    do_point(1'b1);
    do_pause();
    do_point(1'b1);
    n_chk++;
    if (scores !== 8'h01 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL point_outside_play: scores=%h state=%0d, expected 01/3", scores, state);
    end
    do_pause();
    go_serve(c);
    n_chk++;
    if (c >= 50) begin
      n_fail++; $display("FAIL serve_timeout: no serve within %0d cycles", c);
    end
  endtask

  task automatic test_modes();
    int c;
    do_reset();
    load_mode(2'd2);
    n_chk++;
    if (mode !== 2'd2) begin
      n_fail++; $display("FAIL mode_load_idle: mode=%0d, expected 2", mode);
    end
    do_start();
    go_serve(c);
    do_point(1'b0);
    n_chk++;
    if (state !== 3'd4 || winner !== 1'b0 || scores !== 8'h01) begin
      n_fail++;
      $display("FAIL sudden_death: state=%0d winner=%0d scores=%h, expected 4/0/01", state, winner, scores);
    end
    load_mode(2'd3);
    n_chk++;
    if (mode !== 2'd0) begin
      n_fail++; $display("FAIL mode3_as_0: mode=%0d, expected 0", mode);
    end
    load_mode(2'd1);
    do_start();
    for (int i = 0; i < 5; i++) begin
      go_serve(c);
      n_chk++;
      if (c != 4) begin
        n_fail++; $display("FAIL practice_delay%0d: %0d cycles, expected 4", i, c);
      end
      if (i == 0) begin
        load_mode(2'd0);
        n_chk++;
        if (mode !== 2'd1) begin
          n_fail++; $display("FAIL mode_load_play: mode=%0d, expected 1", mode);
        end
      end
      do_point(i[0]);
      sb_q.push_back(i[0]);
      n_chk++;
      if (scores !== 8'h00 || state !== 3'd1 || serve_to !== i[0]) begin
        n_fail++;
        $display("FAIL practice%0d: scores=%h state=%0d serve_to=%0d, expected 00/1/%0d",
                 i, scores, state, serve_to, i[0]);
      end
    end
    go_serve(c);
  endtask

  task automatic test_reset_mid();
    int c;
    logic [0:0] ids [3];
    ids[0] = 1'b0; ids[1] = 1'b0; ids[2] = 1'b1;
    do_reset();
    do_start();
    for (int i = 0; i < 3; i++) begin
      go_serve(c);
      do_point(ids[i]);
      sb_q.push_back(ids[i]);
    end
    do_pause();
    n_chk++;
    if (scores !== 8'h12 || state !== 3'd3) begin
      n_fail++; $display("FAIL pre_reset: scores=%h state=%0d, expected 12/3", scores, state);
    end
    do_reset();
    n_chk++;
    if (state !== 3'd0 || scores !== 8'h00 || serve !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: state=%0d scores=%h serve=%b, expected 0/00/0", state, scores, serve);
    end
    do_start();
    for (int i = 0; i < 3; i++) begin
      go_serve(c);
      do_point(1'b0);
      if (i < 2) sb_q.push_back(1'b0);
    end
    n_chk++;
    if (state !== 3'd4 || scores !== 8'h03 || winner !== 1'b0) begin
      n_fail++;
      $display("FAIL over_p0: state=%0d scores=%h winner=%0d, expected 4/03/0", state, scores, winner);
    end
    do_start();
    n_chk++;
    if (state !== 3'd1 || scores !== 8'h00) begin
      n_fail++; $display("FAIL restart_over: state=%0d scores=%h, expected 1/00", state, scores);
    end
    go_serve(c);
    tick();
  endtask

  initial begin
    test_reset();
    test_serve_timing();
    test_points();
    test_pause();
    test_point_pause();
    test_modes();
    test_reset_mid();
    tick();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d serves outstanding, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
